// File: rtl/midi_pkg.sv
// Shared note/sequencer types and default widths for the synth datapath.
package midi_pkg;

  localparam int unsigned PITCH_W = 7;
  localparam int unsigned INDEX_W = 11;
  localparam int unsigned DUR_W   = 12;

  localparam logic [PITCH_W-1:0] PITCH_REST = '0;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPlay,
    StPause,
    StDone
  } seq_state_t;

endpackage

// File: rtl/note_sequencer_if.sv
// Player/ROM <-> note sequencer signal bundle. The master side drives the controls and the
// ROM data; the slave side is the sequencer.
interface note_sequencer_if #(
  parameter int unsigned INDEX_W = midi_pkg::INDEX_W,
  parameter int unsigned PITCH_W = midi_pkg::PITCH_W,
  parameter int unsigned DUR_W   = midi_pkg::DUR_W
);

  logic               play;
  logic               restart;
  logic [INDEX_W-1:0] song_len;
  logic [INDEX_W-1:0] note_index;
  logic [PITCH_W-1:0] note_pitch;
  logic [DUR_W-1:0]   note_dur;
  logic [PITCH_W-1:0] pitch_out;
  logic               gate;
  logic               note_start;
  logic               song_done;

  modport master (
    output play, restart, song_len, note_pitch, note_dur,
    input  note_index, pitch_out, gate, note_start, song_done
  );

  modport slave (
    input  play, restart, song_len, note_pitch, note_dur,
    output note_index, pitch_out, gate, note_start, song_done
  );

endinterface

// File: rtl/tick_divider.sv
// Prescaler: pulses tick_o for one cycle on every DIV-th enabled cycle; clear_i restarts the count.
module tick_divider #(
  parameter int unsigned DIV = 50_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int unsigned    CntW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = enable_i && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Steps a song through its pitch/duration ROMs and presents the current note to the tone
// generator. Define SEQ_LOOP_EN to wrap to note 0 at the end of the song instead of stopping.
module note_sequencer #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1000,
  parameter int unsigned INDEX_W = midi_pkg::INDEX_W,
  parameter int unsigned PITCH_W = midi_pkg::PITCH_W,
  parameter int unsigned DUR_W   = midi_pkg::DUR_W
) (
  input logic             clk,
  input logic             reset,
  note_sequencer_if.slave bus
);

  import midi_pkg::*;

  localparam int unsigned TickDiv = CLK_HZ / TICK_HZ;

  seq_state_t         state_q;
  logic [INDEX_W-1:0] note_index_q;
  logic [PITCH_W-1:0] pitch_q;
  logic [DUR_W-1:0]   remaining_q;
  logic               gate_q;
  logic               note_start_q;
  logic               song_done_q;

  logic presc_clear;
  logic presc_en;
  logic tick;
  logic last_note;

  always_comb begin
    presc_clear = bus.restart || (state_q == StLoad);
    presc_en    = (state_q == StPlay);
    last_note   = (note_index_q == bus.song_len - INDEX_W'(1));
  end

  tick_divider #(
    .DIV(TickDiv)
  ) u_tick_divider (
    .clk     (clk),
    .reset   (reset),
    .clear_i (presc_clear),
    .enable_i(presc_en),
    .tick_o  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      note_index_q <= '0;
      pitch_q      <= '0;
      remaining_q  <= '0;
      gate_q       <= 1'b0;
      note_start_q <= 1'b0;
      song_done_q  <= 1'b0;
    end else begin
      note_start_q <= 1'b0;
      song_done_q  <= 1'b0;
      if (bus.restart) begin
        note_index_q <= '0;
        pitch_q      <= '0;
        remaining_q  <= '0;
        gate_q       <= 1'b0;
        state_q      <= bus.play ? StLoad : StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            gate_q <= 1'b0;
            if (bus.play) begin
              if (bus.song_len == '0) begin
                song_done_q <= 1'b1;
                state_q     <= StDone;
              end else begin
                state_q <= StLoad;
              end
            end
          end
          StLoad: begin
            pitch_q      <= bus.note_pitch;
            // A zero duration still gets one tick so the note is audible.
            remaining_q  <= (bus.note_dur == '0) ? DUR_W'(1) : bus.note_dur;
            gate_q       <= (bus.note_pitch != PITCH_W'(PITCH_REST));
            note_start_q <= 1'b1;
            state_q      <= StPlay;
          end
          StPlay: begin
            if (tick && (remaining_q == DUR_W'(1))) begin
              gate_q <= 1'b0;
              if (last_note) begin
                song_done_q <= 1'b1;
`ifdef SEQ_LOOP_EN
                note_index_q <= '0;
                state_q      <= StLoad;
`else
                pitch_q <= '0;
                state_q <= StDone;
`endif
              end else begin
                note_index_q <= note_index_q + INDEX_W'(1);
                state_q      <= StLoad;
              end
            end else begin
              if (tick) begin
                remaining_q <= remaining_q - DUR_W'(1);
              end
              if (!bus.play) begin
                gate_q  <= 1'b0;
                state_q <= StPause;
              end
            end
          end
          StPause: begin
            if (bus.play) begin
              gate_q  <= (pitch_q != PITCH_W'(PITCH_REST));
              state_q <= StPlay;
            end
          end
          StDone: begin
            gate_q <= 1'b0;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign bus.note_index = note_index_q;
  assign bus.pitch_out  = pitch_q;
  assign bus.gate       = gate_q;
  assign bus.note_start = note_start_q;
  assign bus.song_done  = song_done_q;

endmodule
